// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single main-memory port between the instruction
// cache and the data cache. The arbiter accepts line refills from either
// cache and dirty-line writebacks from the dcache, and grants them one at a
// time in round-robin order. It routes read responses back as a one-cycle
// fill pulse and raises a sticky error when a response never arrives.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   icache_req_in/_addr_in      icache refill request (held until grant)
//   dcache_req_in/_write_in/
//     _addr_in/_data_in         dcache refill or writeback request
//   icache/dcache_grant_out     current owner of the memory port
//   mem_req_*_out               one-cycle request strobe plus latched payload
//   mem_resp_*_in               memory response / write-ack strobe
//   icache/dcache_fill_out      one-cycle fill pulse to the owner
//   fill_addr_out/_data_out     shared fill payload, held between fills
//   timeout_err_out             sticky response-timeout flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate and latch the winning request
// ISSUE | mem_req_out strobe for one cycle
// WAIT  | waiting for a response whose address matches; timeout runs
// RESP  | owner's fill pulse is high; return to IDLE next cycle

module mem_arbiter #(
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int ADDRESS_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        icache_req_in,
  input  logic [ADDRESS_WIDTH-1:0]    icache_req_addr_in,
  input  logic                        dcache_req_in,
  input  logic                        dcache_req_write_in,
  input  logic [ADDRESS_WIDTH-1:0]    dcache_req_addr_in,
  input  logic [CACHE_LINE_WIDTH-1:0] dcache_req_data_in,
  output logic                        icache_grant_out,
  output logic                        dcache_grant_out,
  output logic                        mem_req_out,
  output logic                        mem_req_write_out,
  output logic [ADDRESS_WIDTH-1:0]    mem_req_addr_out,
  output logic [CACHE_LINE_WIDTH-1:0] mem_req_data_out,
  input  logic                        mem_resp_in,
  input  logic [ADDRESS_WIDTH-1:0]    mem_resp_addr_in,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_resp_data_in,
  output logic                        icache_fill_out,
  output logic                        dcache_fill_out,
  output logic [ADDRESS_WIDTH-1:0]    fill_addr_out,
  output logic [CACHE_LINE_WIDTH-1:0] fill_data_out,
  output logic                        timeout_err_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last WAIT cycle index: counter starts at 0, so WAIT lasts TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);

  // Owner encoding: 0 = icache, 1 = dcache.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                      state_q, state_d;
  logic                        owner_q, owner_d;
  logic                        last_owner_q, last_owner_d;
  logic                        req_write_q, req_write_d;
  logic [ADDRESS_WIDTH-1:0]    req_addr_q, req_addr_d;
  logic [CACHE_LINE_WIDTH-1:0] req_data_q, req_data_d;
  logic                        mem_req_q, mem_req_d;
  logic                        icache_grant_q, icache_grant_d;
  logic                        dcache_grant_q, dcache_grant_d;
  logic                        icache_fill_q, icache_fill_d;
  logic                        dcache_fill_q, dcache_fill_d;
  logic [ADDRESS_WIDTH-1:0]    fill_addr_q, fill_addr_d;
  logic [CACHE_LINE_WIDTH-1:0] fill_data_q, fill_data_d;
  logic                        timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]            tmo_cnt_q, tmo_cnt_d;

  logic winner;
  logic resp_match;

  assign resp_match = mem_resp_in && (mem_resp_addr_in == req_addr_q);

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    req_write_d    = req_write_q;
    req_addr_d     = req_addr_q;
    req_data_d     = req_data_q;
    mem_req_d      = 1'b0;
    icache_grant_d = icache_grant_q;
    dcache_grant_d = dcache_grant_q;
    icache_fill_d  = 1'b0;
    dcache_fill_d  = 1'b0;
    fill_addr_d    = fill_addr_q;
    fill_data_d    = fill_data_q;
    timeout_err_d  = timeout_err_q;
    tmo_cnt_d      = tmo_cnt_q;
    winner         = OWNER_I;

    case (state_q)
      IDLE: begin
        if (icache_req_in || dcache_req_in) begin
          // On a tie the requester not served last wins.
          if (icache_req_in && dcache_req_in) winner = ~last_owner_q;
          else                                winner = dcache_req_in ? OWNER_D : OWNER_I;
          owner_d        = winner;
          last_owner_d   = winner;
          req_addr_d     = (winner == OWNER_D) ? dcache_req_addr_in : icache_req_addr_in;
          req_data_d     = (winner == OWNER_D) ? dcache_req_data_in : '0;
          req_write_d    = (winner == OWNER_D) && dcache_req_write_in;
          mem_req_d      = 1'b1;
          icache_grant_d = (winner == OWNER_I);
          dcache_grant_d = (winner == OWNER_D);
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // A matching response on the final WAIT cycle beats the timeout.
        if (resp_match) begin
          if (req_write_q) begin
            icache_grant_d = 1'b0;
            dcache_grant_d = 1'b0;
            state_d        = IDLE;
          end else begin
            fill_addr_d   = mem_resp_addr_in;
            fill_data_d   = mem_resp_data_in;
            icache_fill_d = (owner_q == OWNER_I);
            dcache_fill_d = (owner_q == OWNER_D);
            state_d       = RESP;
          end
        end else if (tmo_cnt_q >= TMO_LAST) begin
          timeout_err_d  = 1'b1;
          icache_grant_d = 1'b0;
          dcache_grant_d = 1'b0;
          state_d        = IDLE;
        end
        if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
      RESP: begin
        icache_grant_d = 1'b0;
        dcache_grant_d = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= OWNER_I;
      last_owner_q   <= OWNER_I;
      req_write_q    <= 1'b0;
      req_addr_q     <= '0;
      req_data_q     <= '0;
      mem_req_q      <= 1'b0;
      icache_grant_q <= 1'b0;
      dcache_grant_q <= 1'b0;
      icache_fill_q  <= 1'b0;
      dcache_fill_q  <= 1'b0;
      fill_addr_q    <= '0;
      fill_data_q    <= '0;
      timeout_err_q  <= 1'b0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_owner_q   <= last_owner_d;
      req_write_q    <= req_write_d;
      req_addr_q     <= req_addr_d;
      req_data_q     <= req_data_d;
      mem_req_q      <= mem_req_d;
      icache_grant_q <= icache_grant_d;
      dcache_grant_q <= dcache_grant_d;
      icache_fill_q  <= icache_fill_d;
      dcache_fill_q  <= dcache_fill_d;
      fill_addr_q    <= fill_addr_d;
      fill_data_q    <= fill_data_d;
      timeout_err_q  <= timeout_err_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  assign icache_grant_out  = icache_grant_q;
  assign dcache_grant_out  = dcache_grant_q;
  assign mem_req_out       = mem_req_q;
  assign mem_req_write_out = req_write_q;
  assign mem_req_addr_out  = req_addr_q;
  assign mem_req_data_out  = req_data_q;
  assign icache_fill_out   = icache_fill_q;
  assign dcache_fill_out   = dcache_fill_q;
  assign fill_addr_out     = fill_addr_q;
  assign fill_data_out     = fill_data_q;
  assign timeout_err_out   = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int LW = 128;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_req_in;
  logic [AW-1:0] icache_req_addr_in;
  logic          dcache_req_in;
  logic          dcache_req_write_in;
  logic [AW-1:0] dcache_req_addr_in;
  logic [LW-1:0] dcache_req_data_in;
  logic          icache_grant_out;
  logic          dcache_grant_out;
  logic          mem_req_out;
  logic          mem_req_write_out;
  logic [AW-1:0] mem_req_addr_out;
  logic [LW-1:0] mem_req_data_out;
  logic          mem_resp_in;
  logic [AW-1:0] mem_resp_addr_in;
  logic [LW-1:0] mem_resp_data_in;
  logic          icache_fill_out;
  logic          dcache_fill_out;
  logic [AW-1:0] fill_addr_out;
  logic [LW-1:0] fill_data_out;
  logic          timeout_err_out;

  mem_arbiter #(
    .CACHE_LINE_WIDTH(LW),
    .ADDRESS_WIDTH(AW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .icache_req_in(icache_req_in),
    .icache_req_addr_in(icache_req_addr_in),
    .dcache_req_in(dcache_req_in),
    .dcache_req_write_in(dcache_req_write_in),
    .dcache_req_addr_in(dcache_req_addr_in),
    .dcache_req_data_in(dcache_req_data_in),
    .icache_grant_out(icache_grant_out),
    .dcache_grant_out(dcache_grant_out),
    .mem_req_out(mem_req_out),
    .mem_req_write_out(mem_req_write_out),
    .mem_req_addr_out(mem_req_addr_out),
    .mem_req_data_out(mem_req_data_out),
    .mem_resp_in(mem_resp_in),
    .mem_resp_addr_in(mem_resp_addr_in),
    .mem_resp_data_in(mem_resp_data_in),
    .icache_fill_out(icache_fill_out),
    .dcache_fill_out(dcache_fill_out),
    .fill_addr_out(fill_addr_out),
    .fill_data_out(fill_data_out),
    .timeout_err_out(timeout_err_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          ireq;  logic [AW-1:0] iaddr;
    logic          dreq;  logic dwr; logic [AW-1:0] daddr; logic [LW-1:0] ddata;
    logic          resp;  logic [AW-1:0] raddr; logic [LW-1:0] rdata;
    logic          e_igr; logic e_dgr; logic e_mreq; logic e_mwr;
    logic [AW-1:0] e_maddr; logic [LW-1:0] e_mdata;
    logic          e_ifill; logic e_dfill;
    logic [AW-1:0] e_faddr; logic [LW-1:0] e_fdata;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  localparam logic [LW-1:0] D_A5   = {16{8'hA5}};
  localparam logic [LW-1:0] D_1234 = 128'h1234;
  localparam logic [LW-1:0] D_5A   = 128'h5A5A;

  function automatic vec_t mk(
    input logic ireq, input logic [AW-1:0] iaddr,
    input logic dreq, input logic dwr, input logic [AW-1:0] daddr, input logic [LW-1:0] ddata,
    input logic resp, input logic [AW-1:0] raddr, input logic [LW-1:0] rdata,
    input logic e_igr, input logic e_dgr, input logic e_mreq, input logic e_mwr,
    input logic [AW-1:0] e_maddr, input logic [LW-1:0] e_mdata,
    input logic e_ifill, input logic e_dfill,
    input logic [AW-1:0] e_faddr, input logic [LW-1:0] e_fdata, input logic e_err);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwr = dwr; v.daddr = daddr; v.ddata = ddata;
    v.resp = resp; v.raddr = raddr; v.rdata = rdata;
    v.e_igr = e_igr; v.e_dgr = e_dgr; v.e_mreq = e_mreq; v.e_mwr = e_mwr;
    v.e_maddr = e_maddr; v.e_mdata = e_mdata; v.e_ifill = e_ifill; v.e_dfill = e_dfill;
    v.e_faddr = e_faddr; v.e_fdata = e_fdata; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    icache_req_in = 0; icache_req_addr_in = '0;
    dcache_req_in = 0; dcache_req_write_in = 0; dcache_req_addr_in = '0; dcache_req_data_in = '0;
    mem_resp_in = 0; mem_resp_addr_in = '0; mem_resp_data_in = '0;
  endtask

  initial begin
    // Single icache read: req c0, resp c5 on the last allowed WAIT cycle, fill c6.
    vecs.push_back(mk(1,'h100, 0,0,0,0, 0,0,0,      0,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,      1,0,1,0,'h100,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,      1,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,      1,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,      1,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 1,'h100,D_A5, 1,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,      1,0,0,0,0,0, 1,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,      0,0,0,0,0,0, 0,0,'h100,D_A5,0));
    // Dcache writeback: ack c4, grant low c5, no fill.
    vecs.push_back(mk(0,0, 1,1,'h200,D_1234, 0,0,0,    0,0,0,0,0,0, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0, 0,0,0,0,          0,0,0,    0,1,1,1,'h200,D_1234, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0, 0,0,0,0,          0,0,0,    0,1,0,0,0,0, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0, 0,0,0,0,          0,0,0,    0,1,0,0,0,0, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0, 0,0,0,0,          1,'h200,0, 0,1,0,0,0,0, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0, 0,0,0,0,          0,0,0,    0,0,0,0,0,0, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0, 0,0,0,0,          0,0,0,    0,0,0,0,0,0, 0,0,'h100,D_A5,0));
    // Responses in IDLE/ISSUE ignored, mismatched addr ignored, match fills.
    vecs.push_back(mk(1,'h100, 0,0,0,0, 1,'h100,128'hDEAD, 0,0,0,0,0,0, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 1,'h100,128'hDEAD, 1,0,1,0,'h100,0, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,             1,0,0,0,0,0, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 1,'h300,128'hFFFF, 1,0,0,0,0,0, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 1,'h100,D_5A,      1,0,0,0,0,0, 0,0,'h100,D_A5,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,             1,0,0,0,0,0, 1,0,'h100,D_5A,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,             0,0,0,0,0,0, 0,0,'h100,D_5A,0));

    reset = 1;
    drive_idle();
    #2;
    check("rst_igrant", icache_grant_out, 0);
    check("rst_dgrant", dcache_grant_out, 0);
    check("rst_mreq", mem_req_out, 0);
    check("rst_mwr", mem_req_write_out, 0);
    check("rst_maddr", mem_req_addr_out, 0);
    check("rst_mdata", mem_req_data_out, 0);
    check("rst_fills", {icache_fill_out, dcache_fill_out}, 0);
    check("rst_faddr", fill_addr_out, 0);
    check("rst_fdata", fill_data_out, 0);
    check("rst_err", timeout_err_out, 0);
    tick();
    reset = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      icache_req_in       = vecs[i].ireq;
      icache_req_addr_in  = vecs[i].iaddr;
      dcache_req_in       = vecs[i].dreq;
      dcache_req_write_in = vecs[i].dwr;
      dcache_req_addr_in  = vecs[i].daddr;
      dcache_req_data_in  = vecs[i].ddata;
      mem_resp_in         = vecs[i].resp;
      mem_resp_addr_in    = vecs[i].raddr;
      mem_resp_data_in    = vecs[i].rdata;
      check($sformatf("v%0d_igrant", i), icache_grant_out, vecs[i].e_igr);
      check($sformatf("v%0d_dgrant", i), dcache_grant_out, vecs[i].e_dgr);
      check($sformatf("v%0d_mreq", i), mem_req_out, vecs[i].e_mreq);
      if (vecs[i].e_mreq) begin
        check($sformatf("v%0d_mwr", i), mem_req_write_out, vecs[i].e_mwr);
        check($sformatf("v%0d_maddr", i), mem_req_addr_out, vecs[i].e_maddr);
        if (vecs[i].e_mwr) check($sformatf("v%0d_mdata", i), mem_req_data_out, vecs[i].e_mdata);
      end
      check($sformatf("v%0d_ifill", i), icache_fill_out, vecs[i].e_ifill);
      check($sformatf("v%0d_dfill", i), dcache_fill_out, vecs[i].e_dfill);
      check($sformatf("v%0d_faddr", i), fill_addr_out, vecs[i].e_faddr);
      check($sformatf("v%0d_fdata", i), fill_data_out, vecs[i].e_fdata);
      check($sformatf("v%0d_err", i), timeout_err_out, vecs[i].e_err);
      tick();
    end
    drive_idle();

    // Timeout (4 WAIT cycles, c2..c5), error at c6, next request still served.
    icache_req_in = 1; icache_req_addr_in = 'h800;
    tick();
    icache_req_in = 0;
    check("to_issue", mem_req_out, 1);
    tick(); tick(); tick(); tick();
    check("to_last_wait_grant", icache_grant_out, 1);
    check("to_last_wait_err", timeout_err_out, 0);
    tick();
    check("to_err", timeout_err_out, 1);
    check("to_grant_low", icache_grant_out, 0);
    check("to_no_fill", icache_fill_out, 0);
    dcache_req_in = 1; dcache_req_addr_in = 'h900;
    tick();
    dcache_req_in = 0;
    check("to_next_grant", dcache_grant_out, 1);
    check("to_next_addr", mem_req_addr_out, 'h900);
    tick();
    mem_resp_in = 1; mem_resp_addr_in = 'h900; mem_resp_data_in = 128'h42;
    tick();
    drive_idle();
    check("to_next_fill", dcache_fill_out, 1);
    check("to_next_fdata", fill_data_out, 128'h42);
    check("to_err_sticky", timeout_err_out, 1);
    tick();

    // Reset during WAIT: outputs drop at once, late response produces no fill.
    icache_req_in = 1; icache_req_addr_in = 'hA00;
    tick();
    icache_req_in = 0;
    tick(); tick();
    #2 reset = 1;
    #1;
    check("rw_igrant", icache_grant_out, 0);
    check("rw_mreq", mem_req_out, 0);
    check("rw_err", timeout_err_out, 0);
    check("rw_fdata", fill_data_out, 0);
    check("rw_maddr", mem_req_addr_out, 0);
    #2 reset = 0;
    mem_resp_in = 1; mem_resp_addr_in = 'hA00; mem_resp_data_in = 128'h99;
    tick();
    drive_idle();
    check("rw_late_fill", {icache_fill_out, dcache_fill_out}, 0);
    check("rw_late_grant", {icache_grant_out, dcache_grant_out}, 0);
    tick();
    check("rw_late_fill2", {icache_fill_out, dcache_fill_out}, 0);
    check("rw_late_fdata", fill_data_out, 0);

    // Ties after reset: dcache first, icache next (issue 3 cycles after resp), dcache again.
    icache_req_in = 1; icache_req_addr_in = 'h400;
    dcache_req_in = 1; dcache_req_addr_in = 'h500;
    tick();
    check("tie1_dgrant", dcache_grant_out, 1);
    check("tie1_igrant", icache_grant_out, 0);
    check("tie1_maddr", mem_req_addr_out, 'h500);
    dcache_req_in = 0;
    tick();
    tick();
    mem_resp_in = 1; mem_resp_addr_in = 'h500; mem_resp_data_in = 128'h77;
    tick();
    mem_resp_in = 0;
    check("tie1_dfill", dcache_fill_out, 1);
    check("tie1_ifill", icache_fill_out, 0);
    check("tie1_fdata", fill_data_out, 128'h77);
    check("tie1_both_grants", {icache_grant_out, dcache_grant_out}, 2'b01);
    tick();
    check("tie2_idle", {icache_grant_out, dcache_grant_out, mem_req_out}, 0);
    tick();
    check("tie2_issue", mem_req_out, 1);
    check("tie2_igrant", icache_grant_out, 1);
    check("tie2_maddr", mem_req_addr_out, 'h400);
    icache_req_in = 0;
    tick();
    mem_resp_in = 1; mem_resp_addr_in = 'h400; mem_resp_data_in = 128'h88;
    tick();
    mem_resp_in = 0;
    check("tie2_ifill", icache_fill_out, 1);
    check("tie2_fdata", fill_data_out, 128'h88);
    tick();
    icache_req_in = 1; icache_req_addr_in = 'h600;
    dcache_req_in = 1; dcache_req_addr_in = 'h700;
    tick();
    drive_idle();
    check("tie3_dgrant", dcache_grant_out, 1);
    check("tie3_igrant", icache_grant_out, 0);
    check("tie3_maddr", mem_req_addr_out, 'h700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
